pc_fetch_sequencer: RTL
=======================

Name: pc_fetch_sequencer

Overview:
- Sequences the program counter datapath and the instruction memory fetch handshake.
- Owns the word-addressed PC: +1 for the next instruction, PC-relative on a taken branch.
- Issues one fetch at a time, holds the fetched word for decode until it is accepted, then updates the PC.
- Supports start, halt and resume control from the top level.

Parameters:
ADDR_W, 32, PC / instruction address width (word addressed)
DATA_W, 32, instruction word width
RESET_PC, 0, PC value after reset

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  begin or resume fetching (IDLE/HALT only)
halt_req  in  1  stop after the current instruction is accepted
imem_req  out  1  fetch request to instruction memory
imem_addr  out  ADDR_W  fetch address; equals pc while imem_req=1
imem_ack  in  1  memory has valid imem_rdata this cycle
imem_rdata  in  DATA_W  fetched instruction word
instr_valid  out  1  instr_out/instr_pc valid for decode
instr_out  out  DATA_W  held instruction word
instr_pc  out  ADDR_W  address of instr_out
instr_ready  in  1  decode accepts instruction this cycle
branch_taken  in  1  redirect; sampled only on the accept cycle
branch_offset  in  ADDR_W  signed word offset, relative to instr_pc
pc  out  ADDR_W  current PC register
halted  out  1  sequencer in HALT state

Behaviour:
- Reset (async, any state): state=IDLE, pc=RESET_PC, imem_req=0, instr_valid=0, instr_out=0, instr_pc=0, halted=0. Reset mid-fetch abandons the request; a late imem_ack is ignored.
- States: IDLE, FETCH, ISSUE, HALT. The outputs below are registered or derived from state only.
- IDLE:
  - start=1 -> FETCH next cycle.
  - halt_req is ignored.
- FETCH:
  - imem_req=1 and imem_addr=pc, held until imem_ack.
  - On imem_ack: instr_out<=imem_rdata, instr_pc<=pc, instr_valid<=1, go to ISSUE. An ack in the same cycle as the request is legal.
  - halt_req is ignored here; the in-flight fetch always completes.
  - start is ignored.
- ISSUE:
  - instr_valid=1, imem_req=0. instr_out/instr_pc stay stable until accepted.
  - Accept = instr_valid & instr_ready.
  - On accept: pc <= branch_taken ? instr_pc + branch_offset : instr_pc + 1. Arithmetic is modulo 2^ADDR_W, so wrap is silent (pc=0xFFFFFFFF +1 -> 0).
  - On accept: instr_valid<=0, and the next state is HALT if halt_req=1, otherwise FETCH.
  - No accept: stay in ISSUE; branch_taken and halt_req are ignored.
- HALT:
  - halted=1, imem_req=0, pc held.
  - start=1 -> FETCH at the held pc, halted<=0.
  - start and halt_req together: start wins.
- Ignored inputs: imem_ack outside FETCH; branch inputs outside the accept cycle.
- Latency, with start sampled at edge 0:
  - imem_req high after edge 0.
  - Immediate ack -> instr_valid high after edge 1.
  - Ready held high -> accept at edge 2 -> next imem_req after edge 2.
  - Peak throughput is 1 instruction per 2 cycles.
- Invariant: imem_req and instr_valid are never both 1.

Test Plan:
- Reset, start, imem_ack tied 1, instr_ready tied 1, no branches -> imem_addr sequence 0,1,2,3; instr_pc matches; one instruction every 2 cycles.
- Accept instr_pc=5 with branch_taken=1, offset=-3 (0xFFFFFFFD) -> next imem_addr=2. Then offset=+16 at instr_pc=2 -> 18.
- imem_ack delayed 3 cycles -> imem_req and imem_addr=pc held stable for 3 cycles; instr_out = rdata captured on the ack cycle.
- instr_ready low 4 cycles -> instr_out/instr_pc stable, branch_taken pulses ignored, no new fetch.
- halt_req asserted during FETCH and held -> fetch completes; after accept halted=1 with pc=next. start -> fetch resumes at that pc.
- Assert rst while imem_req=1 at pc=7, ack arrives after release -> pc=0, IDLE, instr_valid=0, ack ignored. pc=0xFFFFFFFF +1 -> 0.

Source files
------------

// File: rtl/pc_fetch_sequencer.sv
// Purpose: owns the word-addressed PC and sequences one-at-a-time instruction fetches into a decode holding register.
// Latency: start -> imem_req next cycle; imem_ack -> instr_valid next cycle; accept -> next imem_req next cycle (peak 1 instr / 2 cycles).
// Backpressure: the fetch request is held until imem_ack; the fetched word is held stable while instr_ready is low.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   start, halt_req           top-level run control (start from IDLE/HALT, halt after next accept)
//   imem_req/addr/ack/rdata   instruction memory handshake, one outstanding request
//   instr_valid/out/pc/ready  decode-side holding register and accept handshake
//   branch_taken/offset       PC redirect, sampled only on the accept cycle
//   pc, halted                current PC register and HALT state indication

module pc_fetch_sequencer #(
   parameter int                ADDR_W   = 32,
   parameter int                DATA_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              halt_req,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [DATA_W-1:0] imem_rdata,
   output logic              instr_valid,
   output logic [DATA_W-1:0] instr_out,
   output logic [ADDR_W-1:0] instr_pc,
   input  logic              instr_ready,
   input  logic              branch_taken,
   input  logic [ADDR_W-1:0] branch_offset,
   output logic [ADDR_W-1:0] pc,
   output logic              halted
);

   localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      ISSUE = 2'd2,
      HALT  = 2'd3
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] pcReg;
   logic [ADDR_W-1:0] instrPcReg;
   logic [DATA_W-1:0] instrOutReg;
   logic              imemReqReg;
   logic              instrValidReg;
   logic              haltedReg;

   logic              accept;
   logic [ADDR_W-1:0] nextPc;

   assign accept = instrValidReg & instr_ready;

   // The successor is computed from the held instruction's address, not from
   // pcReg, so a branch is always relative to the instruction that carried it.
   // Both sums wrap modulo 2^ADDR_W.
   assign nextPc = branch_taken ? (instrPcReg + branch_offset)
                                : (instrPcReg + PC_STEP);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         pcReg         <= RESET_PC;
         instrPcReg    <= '0;
         instrOutReg   <= '0;
         imemReqReg    <= 1'b0;
         instrValidReg <= 1'b0;
         haltedReg     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state      <= FETCH;
                  imemReqReg <= 1'b1;
               end
            end

            // The in-flight fetch always completes; start/halt_req have no
            // effect here, halt is evaluated on the accept cycle instead.
            FETCH: begin
               if (imem_ack) begin
                  instrOutReg   <= imem_rdata;
                  instrPcReg    <= pcReg;
                  instrValidReg <= 1'b1;
                  imemReqReg    <= 1'b0;
                  state         <= ISSUE;
               end
            end

            ISSUE: begin
               if (accept) begin
                  pcReg         <= nextPc;
                  instrValidReg <= 1'b0;
                  if (halt_req) begin
                     state     <= HALT;
                     haltedReg <= 1'b1;
                  end else begin
                     state      <= FETCH;
                     imemReqReg <= 1'b1;
                  end
               end
            end

            // start takes priority over a still-asserted halt_req.
            HALT: begin
               if (start) begin
                  state      <= FETCH;
                  imemReqReg <= 1'b1;
                  haltedReg  <= 1'b0;
               end
            end

            default: begin
               state         <= IDLE;
               imemReqReg    <= 1'b0;
               instrValidReg <= 1'b0;
               haltedReg     <= 1'b0;
            end
         endcase
      end
   end

   assign imem_req    = imemReqReg;
   assign imem_addr   = pcReg;
   assign instr_valid = instrValidReg;
   assign instr_out   = instrOutReg;
   assign instr_pc    = instrPcReg;
   assign pc          = pcReg;
   assign halted      = haltedReg;

endmodule
